// File: rtl/iter_comparator_if.sv
// Request/result bundle for iter_comparator: operand request handshake in,
// comparison result handshake out.
interface iter_comparator_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CUW    = $clog2(NCHUNK) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             lt;
    logic             gt;
    logic [CUW-1:0]   chunks_used;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, eq, lt, gt, chunks_used
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, eq, lt, gt, chunks_used
    );
endinterface

// File: rtl/iter_comparator.sv
// Multi-cycle magnitude comparator: walks operand chunks from the MSB down,
// one chunk per cycle, stopping at the first chunk that differs.
module iter_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic              clk,
    input logic              rst_n,
    iter_comparator_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CUW    = $clog2(NCHUNK) + 1;
    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [CUW-1:0]   cu_q, cu_d;
    logic             res_lt_q, res_lt_d;
    logic             res_gt_q, res_gt_d;
    logic             out_valid_q, out_valid_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;

    logic [CHUNK-1:0] ca, cb, msb_mask;
    logic             chunk_lt, chunk_gt;

    // Inverting the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    always_comb begin
        ca                  = a_q[int'(idx_q) * CHUNK +: CHUNK];
        cb                  = b_q[int'(idx_q) * CHUNK +: CHUNK];
        msb_mask            = '0;
        msb_mask[CHUNK-1]   = signed_q && (idx_q == IDX_MSB);
        chunk_lt            = (ca ^ msb_mask) < (cb ^ msb_mask);
        chunk_gt            = (ca ^ msb_mask) > (cb ^ msb_mask);
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        idx_d       = idx_q;
        cu_d        = cu_q;
        res_lt_d    = res_lt_q;
        res_gt_d    = res_gt_q;
        out_valid_d = out_valid_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        gt_d        = gt_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    signed_d = bus.signed_mode;
                    idx_d    = IDX_MSB;
                    cu_d     = '0;
                    state_d  = StCmp;
                end
            end
            StCmp: begin
                cu_d = cu_q + CUW'(1);
                if (chunk_lt || chunk_gt) begin
                    res_lt_d = chunk_lt;
                    res_gt_d = chunk_gt;
                    state_d  = StDone;
                end else if (idx_q == '0) begin
                    res_lt_d = 1'b0;
                    res_gt_d = 1'b0;
                    state_d  = StDone;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            StDone: begin
                // First DONE cycle publishes the result; handshake only once it is visible.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    lt_d        = res_lt_q;
                    gt_d        = res_gt_q;
                    eq_d        = !res_lt_q && !res_gt_q;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    eq_d        = 1'b0;
                    lt_d        = 1'b0;
                    gt_d        = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            idx_q       <= '0;
            cu_q        <= '0;
            res_lt_q    <= 1'b0;
            res_gt_q    <= 1'b0;
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            signed_q    <= signed_d;
            idx_q       <= idx_d;
            cu_q        <= cu_d;
            res_lt_q    <= res_lt_d;
            res_gt_q    <= res_gt_d;
            out_valid_q <= out_valid_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            gt_q        <= gt_d;
        end
    end

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.out_valid   = out_valid_q;
    assign bus.eq          = eq_q;
    assign bus.lt          = lt_q;
    assign bus.gt          = gt_q;
    assign bus.chunks_used = cu_q;

    result_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q |-> $onehot({eq_q, lt_q, gt_q}));
endmodule

// File: tb/tb_iter_comparator.sv
// Self-checking bench for iter_comparator (WIDTH=32, CHUNK=8): directed vector
// table, reset/backpressure sequences, random and back-to-back traffic vs a model.
module tb_iter_comparator;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CUW    = $clog2(NCHUNK) + 1;

    logic clk;
    logic rst_n;

    iter_comparator_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) bus ();

    iter_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [2:0]       elg;   // {eq, lt, gt}
        int               cu;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Whole-word comparison plus "how many chunks from the top until the first difference".
    task automatic ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic s, output logic [2:0] elg, output int cu);
        logic l, g;
        if (s) begin
            l = $signed(a) < $signed(b);
            g = $signed(a) > $signed(b);
        end else begin
            l = a < b;
            g = a > b;
        end
        elg = {a == b, l, g};
        cu  = NCHUNK;
        for (int i = 0; i < NCHUNK; i++) begin
            if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) cu = NCHUNK - i;
        end
    endtask

    task automatic gen_ops(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
        logic [7:0] lo;
        a  = $urandom;
        lo = 8'($urandom);
        case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = a;
            2:       b = a ^ (32'h1 << $urandom_range(0, 31));
            default: b = {a[31:8], lo};
        endcase
    endtask

    // Issues one request and returns at the negedge where out_valid is first seen.
    task automatic start_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s, output int lat);
        @(posedge clk); #2;
        bus.a           = a;
        bus.b           = b;
        bus.signed_mode = s;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b0;
        @(negedge clk);
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #2;
        bus.in_valid    = 1'b0;
        bus.a           = $urandom;
        bus.b           = $urandom;
        bus.signed_mode = 1'($urandom_range(0, 1));
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic s, input int hold,
                           output logic [2:0] elg, output int cu, output int lat);
        start_and_wait(a, b, s, lat);
        elg = {bus.eq, bus.lt, bus.gt};
        cu  = int'(bus.chunks_used);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #2;
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(negedge clk);
            check("hold_stable",
                  64'({bus.out_valid, bus.eq, bus.lt, bus.gt, bus.chunks_used, bus.in_ready}),
                  64'({1'b1, elg, CUW'(cu), 1'b0}));
        end
        @(posedge clk); #2;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("release_clear", 64'({bus.out_valid, bus.eq, bus.lt, bus.gt, bus.in_ready}),
              64'b00001);
        check("cu_hold", 64'(bus.chunks_used), 64'(cu));
    endtask

    initial begin
        logic [2:0]       elg, exp_elg;
        int               cu, exp_cu, lat;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        logic [2:0]       q_elg [$];
        int               q_cu [$];
        int               nreq, nres;
        logic             expect_idle;
        bit               saw_valid;

        vecs[0] = '{32'h12345678, 32'h12345678, 1'b0, 3'b100, 4};
        vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b001, 1};
        vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b010, 1};
        vecs[3] = '{32'h00000105, 32'h00000106, 1'b0, 3'b010, 4};
        vecs[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b010, 4};
        vecs[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b010, 1};
        vecs[6] = '{32'h12340000, 32'h12350000, 1'b0, 3'b010, 2};
        vecs[7] = '{32'h7F00AA00, 32'h7F00A900, 1'b1, 3'b001, 3};
        vecs[8] = '{32'h00800000, 32'h00000000, 1'b1, 3'b001, 2};
        vecs[9] = '{32'h80000000, 32'h80000000, 1'b1, 3'b100, 4};

        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state",
              64'({bus.in_ready, bus.out_valid, bus.eq, bus.lt, bus.gt, bus.chunks_used}),
              64'({1'b1, 4'b0000, CUW'(0)}));
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].s, i % 3, elg, cu, lat);
            check($sformatf("vec%0d_flags", i), 64'(elg), 64'(vecs[i].elg));
            check($sformatf("vec%0d_chunks", i), 64'(cu), 64'(vecs[i].cu));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(1 + vecs[i].cu));
        end

        // Result held five cycles under backpressure while new requests are offered.
        run_txn(32'h00000105, 32'h00000106, 1'b0, 5, elg, cu, lat);
        check("bp_flags", 64'(elg), 64'b010);
        check("bp_chunks", 64'(cu), 64'd4);

        // Reset during the second CMP cycle aborts the operation.
        @(posedge clk); #2;
        bus.a = 32'hCAFEF00D; bus.b = 32'hCAFEF00D; bus.signed_mode = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_cmp_outputs",
              64'({bus.in_ready, bus.out_valid, bus.eq, bus.lt, bus.gt, bus.chunks_used}),
              64'({1'b1, 4'b0000, CUW'(0)}));
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("rst_cmp_no_result", 64'(saw_valid), 64'd0);
        run_txn(32'd5, 32'd3, 1'b0, 0, elg, cu, lat);
        check("post_rst_flags", 64'(elg), 64'b001);
        check("post_rst_chunks", 64'(cu), 64'd4);
        check("post_rst_latency", 64'(lat), 64'd5);

        // Reset while a result is being presented clears it at once.
        start_and_wait(32'h10, 32'h20, 1'b0, lat);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_done_outputs",
              64'({bus.in_ready, bus.out_valid, bus.eq, bus.lt, bus.gt, bus.chunks_used}),
              64'({1'b1, 4'b0000, CUW'(0)}));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 150; i++) begin
            gen_ops(ra, rb);
            rs = 1'($urandom_range(0, 1));
            ref_model(ra, rb, rs, exp_elg, exp_cu);
            run_txn(ra, rb, rs, $urandom_range(0, 3), elg, cu, lat);
            check($sformatf("rnd%0d_flags a=%h b=%h s=%0d", i, ra, rb, rs),
                  64'(elg), 64'(exp_elg));
            check($sformatf("rnd%0d_chunks", i), 64'(cu), 64'(exp_cu));
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(1 + exp_cu));
        end

        // Back-to-back traffic with in_valid and out_ready held high.
        nreq        = 0;
        nres        = 0;
        expect_idle = 1'b0;
        @(posedge clk); #2;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (nreq >= 16 && q_elg.size() == 0) break;
            if (nreq < 16) begin
                gen_ops(ra, rb);
                bus.a           = ra;
                bus.b           = rb;
                bus.signed_mode = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (expect_idle) begin
                check("b2b_idle_between", 64'({bus.in_ready, bus.out_valid}), 64'b10);
                expect_idle = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                ref_model(bus.a, bus.b, bus.signed_mode, exp_elg, exp_cu);
                q_elg.push_back(exp_elg);
                q_cu.push_back(exp_cu);
                nreq++;
            end
            if (bus.out_valid) begin
                if (q_elg.size() == 0) begin
                    check("b2b_spurious_result", 64'd1, 64'd0);
                end else begin
                    exp_elg = q_elg.pop_front();
                    exp_cu  = q_cu.pop_front();
                    check("b2b_flags", 64'({bus.eq, bus.lt, bus.gt}), 64'(exp_elg));
                    check("b2b_chunks", 64'(bus.chunks_used), 64'(exp_cu));
                end
                nres++;
                expect_idle = 1'b1;
            end
            @(posedge clk); #2;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_requests", 64'(nreq), 64'd16);
        check("b2b_count", 64'(nres), 64'(nreq));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
